ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one port of ram_true_dual_port among NUM_REQ requesters via round-robin.
//  Each requester issues a read or write with a valid/ready (req/gnt) handshake.
//  A requester may lock the port for back-to-back bursts.
//  Read data returns with a per-requester rvalid strobe.
//  Sits between client logic and port A or port B of the RAM; one instance per port.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ADDR_W   6  RAM address width
//  DATA_W   8  RAM data width
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous active-low reset
//  req        in   NUM_REQ           request valid, one bit per requester
//  req_we     in   NUM_REQ           1=write, 0=read, per requester
//  req_lock   in   NUM_REQ           keep ownership after this transfer
//  req_addr   in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W    packed write data, same packing
//  gnt        out  NUM_REQ           combinational one-hot ready; transfer = req[i]&gnt[i] at posedge
//  rvalid     out  NUM_REQ           one-cycle strobe: rdata belongs to requester i
//  rdata      out  DATA_W            read data (ram_q passthrough)
//  ram_addr   out  ADDR_W            registered address to RAM port
//  ram_data   out  DATA_W            registered write data to RAM port
//  ram_we     out  1                 registered write enable to RAM port
//  ram_q      in   DATA_W            RAM port output; registered read, valid 1 edge after address sampled
// BEHAVIOUR
//  Reset (async, rst_n=0): ram_we=0, ram_addr=0, ram_data=0, rvalid=0, ptr=0,
//   state=ARB, owner=0, all pipeline valids=0. gnt is 0 while rst_n=0.
//  Reset mid-operation: in-flight reads are dropped; no rvalid after release.
//  FSM ARB: gnt = one-hot of the first requester with req=1, searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
//   On transfer by winner w: ptr<=(w+1)%NUM_REQ.
//   If req_lock[w]=1: state<=LOCK, owner<=w.
//  FSM LOCK: gnt[owner]=req[owner]; all other gnt=0.
//   On transfer with req_lock[owner]=0: ptr<=(owner+1)%NUM_REQ, state<=ARB.
//   If req[owner]=0 for a cycle: state<=ARB, ptr unchanged (no transfer that cycle).
//  gnt depends on req/state/ptr only, never on gnt (no combinational loop). At most one gnt bit high.
//  Issue (edge E0 = transfer edge): ram_addr/ram_data/ram_we <= winner's fields.
//   s1_vld<=1, s1_we<=we, s1_idx<=w. With no transfer: ram_we<=0 and s1_vld<=0; addr/data hold.
//  Read return: RAM samples the address at E1. At E1: rvalid[s1_idx] <= s1_vld&~s1_we, else 0.
//   rdata=ram_q, valid while rvalid is high. Read latency = 2 edges from transfer; throughput 1/cycle.
//  Writes produce no rvalid. ram_we is high exactly one cycle per write transfer.
//  Write to X at Ek followed by read of X at Ek+1 returns the new data (RAM write precedes read).
//  Requester payload is sampled only at its transfer edge. req may drop without a transfer (no penalty).
//  NUM_REQ=1: always grants req[0]; lock is harmless.
// STRUCTURE
//  Package ram_arb_pkg: localparams ST_ARB=1'b0, ST_LOCK=1'b1; default widths ADDR_W/DATA_W.
//  Sub-module rr_pick: combinational round-robin one-hot picker (req, ptr) -> gnt_oh, idx.
//  Top: FSM/ptr/owner regs, issue regs, read-return pipeline.
// TESTING (NUM_REQ=4, ADDR_W=6, DATA_W=8; DUT wired to port A of ram_true_dual_port)
//  1 rst_n=0 mid-stream with a read in flight -> rvalid=0 and ram_we=0 immediately;
//    after release, no stale rvalid and first grant goes to req[0].
//  2 req0 write addr 5 data 8'hAA, then req0 read addr 5 -> gnt0 on both;
//    rvalid[0] 2 edges after the read transfer with rdata=8'hAA.
//  3 req=4'b1111 held, all reads, lock=0 -> grant order 0,1,2,3,0 on consecutive cycles;
//    rvalid order identical.
//  4 req1 with lock=1 for 3 transfers (addr 10,11,12) while req2,req3 are high ->
//    gnt1 for 3 cycles; next gnt goes to 2.
//  5 Locked owner drops req for one cycle -> FSM returns to ARB;
//    pending req3 is granted on the next cycle.
//  6 Write addr 16 data 8'h33 by req2 at Ek, read addr 16 by req3 at Ek+1 ->
//    rvalid[3] with rdata=8'h33; ram_we high exactly one cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter: FSM state encoding,
// default RAM geometry and a small modulo-increment helper.
package ram_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  // Next requester index after i, wrapping at n.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant and index of the first
// asserted request found when searching from ptr upwards, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;
    gnt_oh = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    j      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit keeps ptr+k from overflowing before the wrap.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      j = sum[IDX_W-1:0];
      if (!any && req[j]) begin
        any       = 1'b1;
        gnt_oh[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with
// lockable bursts, registered RAM-side issue and per-requester read strobes.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;

  logic [ADDR_W-1:0]  ram_addr_reg;
  logic [DATA_W-1:0]  ram_data_reg;
  logic               ram_we_reg;
  logic               s1_vld_reg;
  logic               s1_we_reg;
  logic [IDX_W-1:0]   s1_idx_reg;
  logic [NUM_REQ-1:0] rvalid_reg;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_inc;
  logic               xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant is a function of req/state/ptr only, so it never feeds back on itself.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (state_reg == ST_ARB) begin
        gnt = pick_oh;
      end else begin
        gnt[owner_reg] = req[owner_reg];
      end
    end
  end

  assign win_idx = (state_reg == ST_LOCK) ? owner_reg : pick_idx;
  assign win_inc = IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
  assign xfer    = |(req & gnt);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    case (state_reg)
      ST_ARB: begin
        if (xfer && pick_any) begin
          ptr_next = win_inc;
          if (req_lock[win_idx]) begin
            state_next = ST_LOCK;
            owner_next = win_idx;
          end
        end
      end
      ST_LOCK: begin
        // An idle owner forfeits the lock without moving the pointer.
        if (!req[owner_reg]) begin
          state_next = ST_ARB;
        end else if (!req_lock[owner_reg]) begin
          ptr_next   = win_inc;
          state_next = ST_ARB;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ARB;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // Issue stage: the winner's payload is captured only on its transfer edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      ram_we_reg   <= 1'b0;
      s1_vld_reg   <= 1'b0;
      s1_we_reg    <= 1'b0;
      s1_idx_reg   <= '0;
    end else if (xfer) begin
      ram_addr_reg <= addr_arr[win_idx];
      ram_data_reg <= wdata_arr[win_idx];
      ram_we_reg   <= req_we[win_idx];
      s1_vld_reg   <= 1'b1;
      s1_we_reg    <= req_we[win_idx];
      s1_idx_reg   <= win_idx;
    end else begin
      ram_we_reg   <= 1'b0;
      s1_vld_reg   <= 1'b0;
    end
  end

  // The RAM samples the address one edge after issue; its q lines up with this strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= '0;
    end else begin
      rvalid_reg <= '0;
      if (s1_vld_reg && !s1_we_reg) begin
        rvalid_reg[s1_idx_reg] <= 1'b1;
      end
    end
  end

  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;
  assign ram_we   = ram_we_reg;
  assign rvalid   = rvalid_reg;
  assign rdata    = ram_q;

endmodule
